// File: rtl/sig_monitor.sv
// sig_monitor: captures signature stores into a FIFO and flags end-of-test on halt or timeout
module sig_monitor #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] SIG_ADDR = 32'h0000_0F00,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 32'hCAFE_BEEF,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = 500000,
  parameter int CNT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] sig_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [CNT_W-1:0]  sig_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              overflow,
  output logic              halted,
  output logic              timed_out,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] cnt, cnt_n;
  logic run, push, pop, accept, halt_hit, tmo_hit, full;
  logic [DATA_W-1:0] head_n;
  assign sig_valid = cnt != '0;
  always_comb begin
    run = state == RUN;
    push = run && mem_we && mem_addr == SIG_ADDR;
    halt_hit = run && mem_we && mem_addr == HALT_ADDR;
    tmo_hit = run && !halt_hit && cycle_count == CNT_W'(TIMEOUT - 1);
    full = cnt == (PW+1)'(FIFO_DEPTH);
    pop = sig_valid && sig_ready;
    accept = push && (!full || pop);
    cnt_n = cnt + (PW+1)'(accept) - (PW+1)'(pop);
    // sig_data is a register tracking the head; a push into an otherwise-empty FIFO bypasses storage
    head_n = cnt_n == '0 ? sig_data :
             (accept && cnt == (PW+1)'(pop)) ? mem_wdata : mem[rd_ptr + PW'(pop)];
  end
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= mem_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      sig_data <= '0;
      sig_count <= '0;
      cycle_count <= '0;
      overflow <= 1'b0;
      halted <= 1'b0;
      timed_out <= 1'b0;
      done <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_n;
      sig_data <= head_n;
      if (accept && sig_count != '1) sig_count <= sig_count + 1'b1;
      if (push && !accept) overflow <= 1'b1;
      if (run && !tmo_hit) cycle_count <= cycle_count + 1'b1;
      if (halt_hit) halted <= 1'b1;
      if (tmo_hit) timed_out <= 1'b1;
      if (halt_hit || tmo_hit) state <= DRAIN;
      else if (state == DRAIN && cnt == '0) begin
        state <= DONE;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sig_monitor.sv
// tb_sig_monitor: directed stimulus with a queue scoreboard checking every popped signature word
module tb_sig_monitor;
  localparam logic [31:0] SA = 32'h0000_0F00;
  localparam logic [31:0] HA = 32'hCAFE_BEEF;
  logic clk = 1'b0, rst = 1'b1, mem_we = 1'b0, sig_ready = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, sig_data;
  logic [19:0] sig_count, cycle_count;
  logic sig_valid, overflow, halted, timed_out, done;
  logic [31:0] exp_q [$];
  int checks = 0, failures = 0;

  sig_monitor #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sig_data(sig_data), .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_count(sig_count),
    .cycle_count(cycle_count), .overflow(overflow), .halted(halted), .timed_out(timed_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && sig_valid && sig_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h expected no word", sig_data);
      end else check("pop", sig_data, exp_q.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit exp_push);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    if (exp_push) exp_q.push_back(d);
    tick();
    mem_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_we = 1'b0;
    sig_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sig_valid; i++) tick();
    check(name, {31'd0, sig_valid}, 0);
    check({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // reset state and basic capture with halt
    tick();
    do_reset();
    check("rst_valid", {31'd0, sig_valid}, 0);
    check("rst_data", sig_data, 0);
    check("rst_counts", {sig_count, 12'd0} | {12'd0, cycle_count}, 0);
    check("rst_flags", {28'd0, overflow, halted, timed_out, done}, 0);
    sig_ready = 1'b1;
    store(SA, 32'h11, 1);
    check("t1_first_latency", sig_data, 32'h11);
    store(SA, 32'h22, 1);
    store(SA, 32'h33, 1);
    store(HA, 32'h0, 0);
    check("t1_halted", {31'd0, halted}, 1);
    check("t1_empty_after_halt", {31'd0, sig_valid}, 0);
    check("t1_done_not_yet", {31'd0, done}, 0);
    tick();
    check("t1_done", {31'd0, done}, 1);
    check("t1_sig_count", {12'd0, sig_count}, 3);
    check("t1_q_empty", exp_q.size(), 0);
    // overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 6; i++) store(SA, 32'hA0 + i, i < 4);
    check("t2_overflow", {31'd0, overflow}, 1);
    check("t2_sig_count", {12'd0, sig_count}, 4);
    check("t2_head", sig_data, 32'hA0);
    sig_ready = 1'b1;
    drain("t2_drain");
    // push on full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 4; i++) store(SA, 32'hC0 + i, 1);
    check("t3_no_overflow_fill", {31'd0, overflow}, 0);
    sig_ready = 1'b1;
    store(SA, 32'hBB, 1);
    check("t3_overflow", {31'd0, overflow}, 0);
    check("t3_sig_count", {12'd0, sig_count}, 5);
    drain("t3_drain");
    // timeout without halt
    do_reset();
    sig_ready = 1'b1;
    store(SA, 32'h77, 1);
    n = 1;
    while (!timed_out && n < 200) begin
      tick();
      n++;
    end
    check("t4_tmo_edges", n, 64);
    check("t4_timed_out", {31'd0, timed_out}, 1);
    check("t4_cycle_at_tmo", {12'd0, cycle_count}, 63);
    check("t4_halted", {31'd0, halted}, 0);
    tick();
    tick();
    check("t4_done", {31'd0, done}, 1);
    store(SA, 32'h99, 0);
    check("t4_done_ignores_store", {31'd0, sig_valid}, 0);
    check("t4_sig_count", {12'd0, sig_count}, 1);
    check("t4_cycle_frozen", {12'd0, cycle_count}, 63);
    check("t4_q_empty", exp_q.size(), 0);
    // halt on the same cycle as the timeout
    do_reset();
    for (int i = 0; i < 100 && cycle_count != 20'd63; i++) tick();
    check("t5_reach63", {12'd0, cycle_count}, 63);
    store(HA, 32'h1, 0);
    check("t5_halted", {31'd0, halted}, 1);
    check("t5_timed_out", {31'd0, timed_out}, 0);
    tick();
    check("t5_done", {31'd0, done}, 1);
    // mid-test reset discards queued words
    do_reset();
    store(SA, 32'h1, 1);
    store(SA, 32'h2, 1);
    check("t6_pre_count", {12'd0, sig_count}, 2);
    do_reset();
    check("t6_valid", {31'd0, sig_valid}, 0);
    check("t6_counts", {sig_count, 12'd0} | {12'd0, cycle_count}, 0);
    check("t6_flags", {28'd0, overflow, halted, timed_out, done}, 0);
    sig_ready = 1'b1;
    store(SA, 32'h55, 1);
    check("t6_data", sig_data, 32'h55);
    check("t6_valid_after", {31'd0, sig_valid}, 1);
    store(32'h0000_0F04, 32'h66, 0);
    check("t6_other_addr", {12'd0, sig_count}, 1);
    mem_addr = SA;
    mem_wdata = 32'h77;
    tick();
    check("t6_we0", {12'd0, sig_count}, 1);
    check("t6_we0_valid", {31'd0, sig_valid}, 0);
    check("t6_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
